gait_sequencer: RTL and testbench
=================================

# gait_sequencer

Steps a 3-servo leg through a gait table held in a synchronous ROM and feeds the three position values to the ServoUnit PWM generators. It owns the ROM address bus and the step timing. Each step it fetches one word per servo into shadow registers, then commits all three outputs on the same edge so the joints move together. It sits between a gait ROM (genrom) and three ServoUnit instances, and replaces the free-running tic/address counter with start/stop control.

## Interface
- AW, 5: ROM address width. Address = {step[AW-3:0], slot[1:0]}, four words per step.
- DW, 8: ROM data width. Fixed at 8.
- NSTEPS, 8: steps in the gait, 1..2^(AW-2). The step index wraps NSTEPS-1 -> 0.
- STEP_TICKS, 720000: clocks between commits, i.e. 60 ms at 12 MHz. Must be >= 8.
- POS_OFFSET, 46: added to every scaled ROM value.
- REST_POS, 110: value of all position outputs at reset.
- clk  in  1: system clock.
- rstn  in  1: asynchronous, active-low reset.
- start  in  1: level, sampled each edge. Begins the gait when idle.
- stop  in  1: level, sampled each edge. Halts the gait after the current step commits.
- rom_addr  out  AW: registered address to the synchronous ROM.
- rom_data  in  DW: ROM output, valid one clock after rom_addr.
- pos0, pos1, pos2  out  8: registered servo positions for ServoUnit.
- running  out  1: high in any state except IDLE.
- step_done  out  1: one-clock pulse on the commit edge.

## Operation
- States: IDLE, FETCH, CAPTURE, COMMIT, WAIT.
- IDLE
  - Outputs hold their last committed values.
  - start=1 and stop=0 -> FETCH, with step unchanged (0 after reset).
- FETCH / CAPTURE (pipelined)
  - Slots 0, 1, 2 are issued on three consecutive edges.
  - Each rom_data is captured into shadow register i two edges after its address was issued.
  - Slot 3 is reserved and never addressed.
- COMMIT
  - posN <= {1'b0, shadowN[7:1]} + POS_OFFSET, for all three outputs simultaneously.
  - The sum is 8-bit and truncated mod 256. No saturation.
  - step_done=1 for this one clock.
  - Step index advances: step <= (step==NSTEPS-1) ? 0 : step+1.
  - Tick counter is reset. Next state is WAIT, or IDLE if a stop is latched.
- WAIT
  - Counts clocks. At STEP_TICKS-5 -> FETCH, so commit-to-commit is exactly STEP_TICKS clocks.
- stop
  - Latched into stop_pend whenever it is sampled high outside IDLE.
  - Honoured at the next COMMIT. That step is still committed, then the state goes to IDLE.
  - stop_pend clears on entering IDLE.
  - A stop sampled in WAIT aborts the wait immediately -> IDLE, with no further fetch.
- start with stop high on the same edge: stop wins and the block stays IDLE.
- start while running: ignored.
- Resume after stop: restarts at the step that was next. There is no implicit rewind.
- Reset (rstn low, at any time, including mid-fetch)
  - Takes effect immediately: state IDLE, step 0, rom_addr 0, shadows 0.
  - pos0..2 = REST_POS, running 0, step_done 0, stop_pend 0, tick counter 0.

## Timing
- Latency from the edge E0 that samples start in IDLE:
  - rom_addr = slot0 / slot1 / slot2 after E0 / E1 / E2.
  - Captures occur at E2 / E3 / E4.
  - The commit edge is E5, which sets pos and step_done.
  - running rises after E0.
- Step period: commits at E5, E5+STEP_TICKS, E5+2*STEP_TICKS, and so on. Zero drift.
- rom_addr holds its last value in WAIT and IDLE.
- All outputs are registered. There are no combinational paths from start or stop to outputs.

## Test plan
- Reset, then hold idle for 20 clocks.
  - pos0..2=110, running=0, rom_addr=0, no step_done pulse.
- Setup: STEP_TICKS=16, NSTEPS=2. ROM step0 = {0x00, 0x80, 0xFE}, step1 = {0x40, 0x41, 0xFF}. Pulse start.
  - At E5: pos = 46 / 110 / 173, step_done for one clock.
  - At E21: pos = 78 / 78 / 173.
  - At E37: the step0 values return (wrap).
- Assert stop during WAIT of step1.
  - Goes IDLE on the next edge, and pos holds the step1 values.
  - A later start fetches step0, with the first commit 5 edges after start.
- Assert stop at E3 of a fetch.
  - That step still commits at E5, then IDLE.
  - running falls after E5. No further rom_addr change.
- start and stop high together in IDLE: stays IDLE, running=0.
- Pull rstn low at E3 of a fetch.
  - Outputs immediately return to their reset values and no commit occurs.
  - After release, start resumes from step0.

Source files
------------

// File: rtl/gait_sequencer.sv
// Gait sequencer: steps a 3-servo leg through a gait table held in a
// synchronous ROM. Each step fetches three words into shadow registers,
// then commits all three positions on one edge so the joints move together.
// Commit-to-commit spacing is exactly STEP_TICKS clocks; start/stop give
// run control. All outputs are registered.
module gait_sequencer #(
    parameter int AW         = 5,
    parameter int DW         = 8,
    parameter int NSTEPS     = 8,
    parameter int STEP_TICKS = 720000,
    parameter int POS_OFFSET = 46,
    parameter int REST_POS   = 110
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [7:0]    pos0,
    output logic [7:0]    pos1,
    output logic [7:0]    pos2,
    output logic          running,
    output logic          step_done,
    output logic [2:0]    dbg_state
);

    localparam int SW = AW - 2;
    localparam int TW = $clog2(STEP_TICKS);
    // WAIT leaves on this count so fetch+capture+commit (5 edges) lands
    // exactly STEP_TICKS clocks after the previous commit.
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 6);
    localparam logic [7:0]    OFFSET    = 8'(POS_OFFSET);
    localparam logic [7:0]    REST      = 8'(REST_POS);
    localparam logic [SW-1:0] STEP_LAST = SW'(NSTEPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        COMMIT  = 3'd3,
        WAIT    = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] step;
    logic [1:0]    phase;      // 0..1 in FETCH, 2..3 in CAPTURE
    logic [TW-1:0] tick;
    logic          stop_pend;
    logic [7:0]    sh0, sh1, sh2;

    assign running   = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a stop seen in WAIT aborts before any new fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = FETCH;
            FETCH:   if (phase == 2'd1) state_nxt = CAPTURE;
            CAPTURE: if (phase == 2'd3) state_nxt = COMMIT;
            COMMIT:  state_nxt = (stop_pend || stop) ? IDLE : WAIT;
            WAIT: begin
                if (stop)                   state_nxt = IDLE;
                else if (tick == TICK_LAST) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address issue, shadow capture (two edges after issue), commit and timing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_addr  <= '0;
            step      <= '0;
            phase     <= '0;
            tick      <= '0;
            stop_pend <= 1'b0;
            sh0       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            pos0      <= REST;
            pos1      <= REST;
            pos2      <= REST;
            step_done <= 1'b0;
        end else begin
            step_done <= (state == COMMIT);

            if (state_nxt == IDLE)
                stop_pend <= 1'b0;
            else if (state != IDLE && stop)
                stop_pend <= 1'b1;

            if (state == WAIT)
                tick <= tick + 1'b1;

            case (state)
                IDLE, WAIT: begin
                    if (state_nxt == FETCH) begin
                        rom_addr <= {step, 2'd0};
                        phase    <= 2'd0;
                    end
                end
                FETCH: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd0) begin
                        rom_addr <= {step, 2'd1};
                    end else begin
                        rom_addr <= {step, 2'd2};
                        sh0      <= rom_data[7:0];
                    end
                end
                CAPTURE: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd2) sh1 <= rom_data[7:0];
                    else               sh2 <= rom_data[7:0];
                end
                COMMIT: begin
                    pos0 <= (sh0 >> 1) + OFFSET;
                    pos1 <= (sh1 >> 1) + OFFSET;
                    pos2 <= (sh2 >> 1) + OFFSET;
                    step <= (step == STEP_LAST) ? '0 : step + 1'b1;
                    tick <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gait_sequencer.sv
// Bench for gait_sequencer: fixed gait table scenarios plus randomized
// ROM contents checked against a simple arithmetic model of the gait.
module tb_gait_sequencer;

    localparam int AW         = 5;
    localparam int NSTEPS     = 2;
    localparam int STEP_TICKS = 16;
    localparam int POS_OFFSET = 46;
    localparam int REST_POS   = 110;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [7:0]    pos0, pos1, pos2;
    logic          running, step_done;
    logic [2:0]    dbg_state;

    logic [7:0]    rom [0:31];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [23:0]   exp_q[$];
    int            exp_step = 0;

    gait_sequencer #(
        .AW(AW), .DW(8), .NSTEPS(NSTEPS), .STEP_TICKS(STEP_TICKS),
        .POS_OFFSET(POS_OFFSET), .REST_POS(REST_POS)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pos0(pos0), .pos1(pos1), .pos2(pos2),
        .running(running), .step_done(step_done), .dbg_state(dbg_state)
    );

    // Clock and synchronous gait ROM.
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Model: position = floor(rom/2) + offset, mod 256.
    function automatic logic [7:0] model_pos(input int s, input int k);
        int v;
        v = int'(rom[s * 4 + k]);
        return 8'((v / 2 + POS_OFFSET) % 256);
    endfunction

    function automatic logic [23:0] model_word(input int s);
        return {model_pos(s, 0), model_pos(s, 1), model_pos(s, 2)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic stop_now();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_commit(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if (step_done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        start = 1'b0;
        stop  = 1'b0;
        rstn  = 1'b0;
        repeat (3) cycle();
        rstn = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        start = 1'b0;
        stop  = 1'b0;
        rstn  = 1'b0;
        repeat (2) cycle();
        n_checks++;
        if ({pos0, pos1, pos2, running, step_done, rom_addr, dbg_state} !==
            {8'd110, 8'd110, 8'd110, 1'b0, 1'b0, 5'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got %h %h %h run=%b done=%b addr=%h, expected 6e 6e 6e run=0 done=0 addr=00",
                     pos0, pos1, pos2, running, step_done, rom_addr);
        end
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({pos0, pos1, pos2, running, step_done, rom_addr} !==
                {8'd110, 8'd110, 8'd110, 1'b0, 1'b0, 5'd0}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h %h %h run=%b done=%b addr=%h, expected 6e 6e 6e run=0 done=0 addr=00",
                         i, pos0, pos1, pos2, running, step_done, rom_addr);
            end
        end
    endtask

    task automatic test_gait();
        int c;
        rom[0] = 8'h00; rom[1] = 8'h80; rom[2] = 8'hFE; rom[3] = 8'hA5;
        rom[4] = 8'h40; rom[5] = 8'h41; rom[6] = 8'hFF; rom[7] = 8'h5A;
        pulse_start();
        n_checks++;
        if ({running, rom_addr} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL gait_e0: run=%b addr=%h, expected run=1 addr=00", running, rom_addr);
        end
        cycle();
        n_checks++;
        if (rom_addr !== 5'd1) begin
            n_fail++;
            $display("FAIL gait_e1_addr: got %h expected 01", rom_addr);
        end
        cycle();
        n_checks++;
        if (rom_addr !== 5'd2) begin
            n_fail++;
            $display("FAIL gait_e2_addr: got %h expected 02", rom_addr);
        end
        wait_commit(10, c);
        n_checks++;
        if (c !== 3 || {pos0, pos1, pos2} !== {8'd46, 8'd110, 8'd173}) begin
            n_fail++;
            $display("FAIL gait_e5: cycles=%0d pos=%0d/%0d/%0d, expected cycles=3 pos=46/110/173",
                     c, pos0, pos1, pos2);
        end
        cycle();
        n_checks++;
        if ({step_done, rom_addr} !== {1'b0, 5'd2}) begin
            n_fail++;
            $display("FAIL gait_pulse_hold: done=%b addr=%h, expected done=0 addr=02", step_done, rom_addr);
        end
        wait_commit(20, c);
        n_checks++;
        if (c !== 15 || {pos0, pos1, pos2} !== {8'd78, 8'd78, 8'd173}) begin
            n_fail++;
            $display("FAIL gait_e21: cycles=%0d pos=%0d/%0d/%0d, expected cycles=15 pos=78/78/173",
                     c, pos0, pos1, pos2);
        end
        wait_commit(20, c);
        n_checks++;
        if (c !== 16 || {pos0, pos1, pos2} !== {8'd46, 8'd110, 8'd173}) begin
            n_fail++;
            $display("FAIL gait_e37_wrap: cycles=%0d pos=%0d/%0d/%0d, expected cycles=16 pos=46/110/173",
                     c, pos0, pos1, pos2);
        end
    endtask

    task automatic test_stop_wait();
        int c;
        wait_commit(20, c);
        n_checks++;
        if (c !== 16 || {pos0, pos1, pos2} !== {8'd78, 8'd78, 8'd173}) begin
            n_fail++;
            $display("FAIL stopw_commit: cycles=%0d pos=%0d/%0d/%0d, expected cycles=16 pos=78/78/173",
                     c, pos0, pos1, pos2);
        end
        repeat (3) cycle();
        stop_now();
        n_checks++;
        if ({running, pos0, pos1, pos2} !== {1'b0, 8'd78, 8'd78, 8'd173}) begin
            n_fail++;
            $display("FAIL stopw_idle: run=%b pos=%0d/%0d/%0d, expected run=0 pos=78/78/173",
                     running, pos0, pos1, pos2);
        end
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if ({step_done, running, rom_addr} !== {1'b0, 1'b0, 5'd6}) begin
                n_fail++;
                $display("FAIL stopw_quiet[%0d]: done=%b run=%b addr=%h, expected done=0 run=0 addr=06",
                         i, step_done, running, rom_addr);
            end
        end
        pulse_start();
        wait_commit(10, c);
        n_checks++;
        if (c !== 5 || {pos0, pos1, pos2} !== {8'd46, 8'd110, 8'd173}) begin
            n_fail++;
            $display("FAIL stopw_resume: cycles=%0d pos=%0d/%0d/%0d, expected cycles=5 pos=46/110/173",
                     c, pos0, pos1, pos2);
        end
        repeat (2) cycle();
        stop_now();
    endtask

    task automatic test_stop_fetch();
        int c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        wait_commit(10, c);
        n_checks++;
        if (c !== 2 || {pos0, pos1, pos2} !== {8'd78, 8'd78, 8'd173} || running !== 1'b0) begin
            n_fail++;
            $display("FAIL stopf_commit: cycles=%0d pos=%0d/%0d/%0d run=%b, expected cycles=2 pos=78/78/173 run=0",
                     c, pos0, pos1, pos2, running);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({step_done, running, rom_addr} !== {1'b0, 1'b0, 5'd6}) begin
                n_fail++;
                $display("FAIL stopf_quiet[%0d]: done=%b run=%b addr=%h, expected done=0 run=0 addr=06",
                         i, step_done, running, rom_addr);
            end
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if ({running, step_done, rom_addr} !== {1'b0, 1'b0, 5'd6}) begin
                n_fail++;
                $display("FAIL startstop[%0d]: run=%b done=%b addr=%h, expected run=0 done=0 addr=06",
                         i, running, step_done, rom_addr);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_fetch();
        int c;
        pulse_start();
        wait_commit(10, c);
        n_checks++;
        if (c !== 5 || {pos0, pos1, pos2} !== {8'd46, 8'd110, 8'd173}) begin
            n_fail++;
            $display("FAIL rstf_pre: cycles=%0d pos=%0d/%0d/%0d, expected cycles=5 pos=46/110/173",
                     c, pos0, pos1, pos2);
        end
        repeat (2) cycle();
        stop_now();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if ({pos0, pos1, pos2, running, step_done, rom_addr} !==
            {8'd110, 8'd110, 8'd110, 1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL rstf_immediate: pos=%0d/%0d/%0d run=%b done=%b addr=%h, expected 110/110/110 run=0 done=0 addr=00",
                     pos0, pos1, pos2, running, step_done, rom_addr);
        end
        @(negedge clk);
        repeat (2) cycle();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if ({step_done, running, pos0} !== {1'b0, 1'b0, 8'd110}) begin
                n_fail++;
                $display("FAIL rstf_quiet[%0d]: done=%b run=%b pos0=%0d, expected done=0 run=0 pos0=110",
                         i, step_done, running, pos0);
            end
        end
        pulse_start();
        n_checks++;
        if (rom_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL rstf_restart_addr: got %h expected 00", rom_addr);
        end
        wait_commit(10, c);
        n_checks++;
        if (c !== 5 || {pos0, pos1, pos2} !== {8'd46, 8'd110, 8'd173}) begin
            n_fail++;
            $display("FAIL rstf_restart: cycles=%0d pos=%0d/%0d/%0d, expected cycles=5 pos=46/110/173",
                     c, pos0, pos1, pos2);
        end
        repeat (2) cycle();
        stop_now();
    endtask

    task automatic test_random();
        int c, n, k;
        logic [23:0] exp_w, last_w;
        apply_reset();
        exp_step = 0;
        last_w   = {8'd110, 8'd110, 8'd110};
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 8; a++) rom[a] = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) cycle();
            n = $urandom_range(2, 5);
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(model_word(exp_step));
                exp_step = (exp_step + 1) % NSTEPS;
            end
            pulse_start();
            for (int j = 0; j < n; j++) begin
                wait_commit(20, c);
                exp_w  = exp_q.pop_front();
                last_w = exp_w;
                n_checks++;
                if (c !== ((j == 0) ? 5 : 16) || {pos0, pos1, pos2} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rand_commit[%0d.%0d]: cycles=%0d pos=%h, expected cycles=%0d pos=%h",
                             r, j, c, {pos0, pos1, pos2}, (j == 0) ? 5 : 16, exp_w);
                end
            end
            k = $urandom_range(1, 9);
            repeat (k - 1) cycle();
            stop_now();
            n_checks++;
            if ({running, step_done, pos0, pos1, pos2} !== {1'b0, 1'b0, last_w}) begin
                n_fail++;
                $display("FAIL rand_stop[%0d]: run=%b done=%b pos=%h, expected run=0 done=0 pos=%h",
                         r, running, step_done, {pos0, pos1, pos2}, last_w);
            end
        end
    endtask

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        test_reset();
        test_gait();
        test_stop_wait();
        test_stop_fetch();
        test_start_stop();
        test_reset_mid_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
